temp_monitor: RTL and testbench
===============================

// Module: temp_monitor
// PURPOSE
//  Sits downstream of the I2C temperature reader and consumes its 17-bit sign-magnitude result.
//  - Samples the reading periodically and computes block averages.
//  - Raises an over-temperature alarm with hysteresis.
//  - Exposes all results to the core through the peripheral register bus.
// PARAMETERS
//  SAMPLE_DIV  50000  clk cycles between samples (>=2)
//  AVG_LOG2    3      average window = 2**AVG_LOG2 samples (0..6)
// PORTS
//  clk        in   1   system clock
//  rst        in   1   synchronous reset, active-high
//  we_i       in   1   bus write strobe
//  addr_i     in   32  bus address; register select = addr_i[23:16]
//  data_i     in   32  bus write data
//  data_o     out  32  bus read data (combinational from addr_i)
//  temp_i     in   17  [16]=sign, [15:0]=magnitude, from I2C reader
//  alarm_o    out  1   registered alarm level
//  irq_o      out  1   = sticky event bit AND CTRL.irq_en
// BEHAVIOUR
//  Interface: one clock, clk. Reset rst is synchronous and active-high. All state is updated on posedge clk only.
//  Reset values:
//   - data_o = 0 while rst=1. alarm_o = 0, irq_o = 0.
//   - acc, sample count, avg = 0. avg_valid = 0.
//   - CTRL = 0. TH_HI = 18'sh1FFFF. TH_LO = 18'sh20000. FSM = NORMAL.
//  Registers (addr_i[23:16]); reads of unlisted addresses return 0; writes to them are ignored:
//   0x1 CTRL   RW  [0]=enable, [1]=irq_en
//   0x2 TH_HI  RW  [17:0] signed two's-complement threshold
//   0x3 TH_LO  RW  [17:0] signed two's-complement threshold
//   0x4 AVG    RO  last average, sign-extended to 32 bits
//   0x5 STATUS [0]=alarm (RO), [1]=event (W1C), [2]=avg_valid (RO)
//   0x6 MIN    RO  minimum sample, sign-extended; any write re-arms MIN and MAX
//   0x7 MAX    RO  maximum sample, sign-extended
//  Conversion: s = temp_i[16] ? -{2'b0,temp_i[15:0]} : {2'b0,temp_i[15:0]}, an 18-bit signed value. Negative zero maps to 0.
//  Prescaler:
//   - Counts 0..SAMPLE_DIV-1 while CTRL.enable=1.
//   - Emits a one-cycle strobe at SAMPLE_DIV-1, then wraps to 0.
//   - Held at 0 while enable=0.
//  Accumulator: width 18+AVG_LOG2 bits, signed.
//   - On a strobe, s is added and the sample count increments.
//   - On the 2**AVG_LOG2-th strobe (same cycle): avg <= (acc+s)>>>AVG_LOG2 (arithmetic, floor); acc <= 0; count <= 0; avg_valid <= 1; the FSM evaluates on the next cycle.
//   - Clearing enable mid-window discards the partial acc and count. avg is kept.
//  Alarm FSM, evaluated one cycle after each avg update:
//   - NORMAL -> ALARM when avg > TH_HI (signed compare). Sets alarm_o=1 and event=1.
//   - ALARM -> NORMAL when avg < TH_LO. Sets alarm_o=0 and event=1.
//   - avg between the thresholds: no state change.
//   - TH_LO >= TH_HI is legal: each exit test uses its own threshold only.
//  Event bit:
//   - Written as 1 to STATUS[1] clears it.
//   - If a set and a W1C occur in the same cycle, the set wins.
//  Threshold writes take effect at the next evaluation; they never re-evaluate the old avg.
//  Reset mid-operation: all state returns to reset values on the next edge.
// CONFIGURATION
//  TEMP_MINMAX_EN defined:
//   - MIN/MAX track the signed extremes of every strobed s.
//   - The first strobe after reset or re-arm loads s into both MIN and MAX.
//   - A write to 0x6 re-arms; if it coincides with a strobe, the re-arm wins and that sample is ignored.
//  TEMP_MINMAX_EN undefined: no MIN/MAX storage; 0x6 and 0x7 read 0; writes are ignored.
// TESTING
//  1. AVG_LOG2=2, SAMPLE_DIV=4, enable=1, temp_i=17'h00064 (+100) -> AVG reads 100, avg_valid=1 after 16 cycles.
//  2. Samples +3,+3,-4,-4 (temp_i[16]=1 for the negatives) -> AVG = -1 (floor of -2/4); -0 input -> s=0.
//  3. TH_HI=50, TH_LO=40; avg sequence 45,51,45,39 ->
//     - alarm_o=0,1,1,0;
//     - event set at 51 and at 39; irq_o follows when irq_en=1.
//  4. W1C of STATUS[1] in the same cycle as an alarm transition -> event stays 1; a later W1C clears it to 0.
//  5. With TEMP_MINMAX_EN: samples 10,-20,30 -> MIN=-20, MAX=30. Write 0x6, then sample 5 -> MIN=MAX=5. Without the macro, 0x6 and 0x7 read 0.
//  6. Assert rst mid-window with the alarm active -> the next cycle shows alarm_o=0, AVG=0, STATUS=0, CTRL=0.

Source files
------------

// File: rtl/temp_monitor.sv
// Temperature monitor: periodic sampling, block averaging, hysteresis alarm, register bus access.
// Optional MIN/MAX tracking is built when TEMP_MINMAX_EN is defined.
module temp_monitor #(
  parameter int SAMPLE_DIV = 50000,
  parameter int AVG_LOG2   = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  input  logic [16:0] temp_i,
  output logic        alarm_o,
  output logic        irq_o
);

  localparam int CW = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
  localparam int AW = 18 + AVG_LOG2;
  localparam int NW = AVG_LOG2 + 1;
  localparam logic [CW-1:0] PRE_LAST = CW'(SAMPLE_DIV - 1);
  localparam logic [NW-1:0] CNT_LAST = NW'((1 << AVG_LOG2) - 1);

  typedef enum logic {NORMAL, ALARM} state_t;

  logic [7:0] sel;
  logic       wr_ctrl, wr_thhi, wr_thlo, wr_status;
  assign sel       = addr_i[23:16];
  assign wr_ctrl   = we_i && (sel == 8'h01);
  assign wr_thhi   = we_i && (sel == 8'h02);
  assign wr_thlo   = we_i && (sel == 8'h03);
  assign wr_status = we_i && (sel == 8'h05);

  logic unused_bits;
  assign unused_bits = ^{addr_i[31:24], addr_i[15:0], data_i[31:18]};

  logic        [1:0]    ctrl_q;
  logic signed [17:0]   th_hi_q, th_lo_q;
  logic        [CW-1:0] pre_q, pre_d;
  logic signed [AW-1:0] acc_q, acc_d, s_ext, sum;
  logic        [NW-1:0] cnt_q, cnt_d;
  logic signed [17:0]   avg_q, avg_d;
  logic                 avgv_q, avgv_d;
  logic                 eval_q, eval_d;
  logic                 event_q, event_d, ev_set;
  state_t               state_q, state_d;

  logic signed [17:0] mag, s;
  logic               strobe;

  // Sign-magnitude to two's complement; negative zero falls out as 0.
  assign mag    = {2'b00, temp_i[15:0]};
  assign s      = temp_i[16] ? -mag : mag;
  assign s_ext  = s;
  assign sum    = acc_q + s_ext;
  assign strobe = ctrl_q[0] && (pre_q == PRE_LAST);

  always_comb begin
    pre_d  = '0;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    avg_d  = avg_q;
    avgv_d = avgv_q;
    eval_d = 1'b0;
    if (!ctrl_q[0]) begin
      acc_d = '0;
      cnt_d = '0;
    end else begin
      pre_d = strobe ? '0 : pre_q + CW'(1);
      if (strobe) begin
        if (cnt_q == CNT_LAST) begin
          avg_d  = 18'(sum >>> AVG_LOG2);
          acc_d  = '0;
          cnt_d  = '0;
          avgv_d = 1'b1;
          eval_d = 1'b1;
        end else begin
          acc_d = sum;
          cnt_d = cnt_q + NW'(1);
        end
      end
    end
  end

  // Alarm FSM looks at the average one cycle after it lands.
  always_comb begin
    state_d = state_q;
    ev_set  = 1'b0;
    if (eval_q) begin
      case (state_q)
        NORMAL: if (avg_q > th_hi_q) begin state_d = ALARM;  ev_set = 1'b1; end
        ALARM:  if (avg_q < th_lo_q) begin state_d = NORMAL; ev_set = 1'b1; end
        default: state_d = NORMAL;
      endcase
    end
    event_d = event_q;
    if (ev_set)                       event_d = 1'b1;
    else if (wr_status && data_i[1])  event_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q  <= '0;
      th_hi_q <= 18'sh1FFFF;
      th_lo_q <= 18'sh20000;
      pre_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      avg_q   <= '0;
      avgv_q  <= 1'b0;
      eval_q  <= 1'b0;
      event_q <= 1'b0;
      state_q <= NORMAL;
    end else begin
      if (wr_ctrl) ctrl_q  <= data_i[1:0];
      if (wr_thhi) th_hi_q <= data_i[17:0];
      if (wr_thlo) th_lo_q <= data_i[17:0];
      pre_q   <= pre_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      avg_q   <= avg_d;
      avgv_q  <= avgv_d;
      eval_q  <= eval_d;
      event_q <= event_d;
      state_q <= state_d;
    end
  end

  assign alarm_o = (state_q == ALARM);
  assign irq_o   = event_q & ctrl_q[1];

`ifdef TEMP_MINMAX_EN
  logic signed [17:0] min_q, min_d, max_q, max_d;
  logic               mmv_q, mmv_d;
  logic               wr_mm;
  assign wr_mm = we_i && (sel == 8'h06);

  // Re-arm beats a coincident strobe: that sample is dropped.
  always_comb begin
    min_d = min_q;
    max_d = max_q;
    mmv_d = mmv_q;
    if (wr_mm) begin
      mmv_d = 1'b0;
    end else if (strobe) begin
      mmv_d = 1'b1;
      if (!mmv_q || s < min_q) min_d = s;
      if (!mmv_q || s > max_q) max_d = s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      min_q <= '0;
      max_q <= '0;
      mmv_q <= 1'b0;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
      mmv_q <= mmv_d;
    end
  end
`endif

  always_comb begin
    data_o = '0;
    if (!rst) begin
      case (sel)
        8'h01: data_o = {30'b0, ctrl_q};
        8'h02: data_o = {14'b0, th_hi_q};
        8'h03: data_o = {14'b0, th_lo_q};
        8'h04: data_o = {{14{avg_q[17]}}, avg_q};
        8'h05: data_o = {29'b0, avgv_q, event_q, alarm_o};
`ifdef TEMP_MINMAX_EN
        8'h06: data_o = {{14{min_q[17]}}, min_q};
        8'h07: data_o = {{14{max_q[17]}}, max_q};
`endif
        default: data_o = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_temp_monitor.sv
// Bench for temp_monitor: integer-level model checked every cycle, plus directed literal checks.
module tb_temp_monitor;
  localparam int DIV = 4;
  localparam int L   = 2;
  localparam int N   = 1 << L;

  logic        clk = 1'b0, rst = 1'b1, we_i = 1'b0;
  logic [31:0] addr_i = '0, data_i = '0;
  logic [16:0] temp_i = '0;
  logic [31:0] data_o;
  logic        alarm_o, irq_o;

  temp_monitor #(.SAMPLE_DIV(DIV), .AVG_LOG2(L)) dut (
    .clk(clk), .rst(rst), .we_i(we_i), .addr_i(addr_i), .data_i(data_i),
    .data_o(data_o), .temp_i(temp_i), .alarm_o(alarm_o), .irq_o(irq_o));

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  // Model state in plain integers.
  logic [1:0] m_ctrl = 2'b00;
  int  m_thhi = 131071, m_thlo = -131072;
  int  m_avg = 0, m_phase = 0, m_avg_cnt = 0, m_min = 0, m_max = 0;
  bit  m_avgv = 0, m_alarm = 0, m_event = 0, m_eval = 0, m_mmv = 0;
  int  q[$];

  function automatic int s_of(logic [16:0] t);
    return t[16] ? -int'(t[15:0]) : int'(t[15:0]);
  endfunction

  function automatic int floor_div(int a, int n);
    if (a >= 0) return a / n;
    return -((-a + n - 1) / n);
  endfunction

  always @(posedge clk) begin : model
    bit strobe, evset;
    int sum, sv;
    logic signed [17:0] th;
    logic [7:0] sl;
    sl = addr_i[23:16];
    if (rst) begin
      m_ctrl = 2'b00; m_thhi = 131071; m_thlo = -131072; m_avg = 0; m_phase = 0;
      m_avgv = 0; m_alarm = 0; m_event = 0; m_eval = 0; m_mmv = 0; m_min = 0; m_max = 0;
      q.delete();
    end else begin
      strobe  = m_ctrl[0] && (m_phase == DIV - 1);
      m_phase = m_ctrl[0] ? (strobe ? 0 : m_phase + 1) : 0;
      evset = 0;
      if (m_eval) begin
        if (!m_alarm && m_avg > m_thhi)     begin m_alarm = 1; evset = 1; end
        else if (m_alarm && m_avg < m_thlo) begin m_alarm = 0; evset = 1; end
      end
      m_eval = 0;
      sv = s_of(temp_i);
      if (!m_ctrl[0]) q.delete();
      else if (strobe) begin
        q.push_back(sv);
        if (q.size() == N) begin
          sum = 0;
          foreach (q[i]) sum += q[i];
          m_avg = floor_div(sum, N);
          m_avgv = 1; m_eval = 1; m_avg_cnt++;
          q.delete();
        end
      end
`ifdef TEMP_MINMAX_EN
      if (we_i && sl == 8'h06) m_mmv = 0;
      else if (strobe) begin
        if (!m_mmv || sv < m_min) m_min = sv;
        if (!m_mmv || sv > m_max) m_max = sv;
        m_mmv = 1;
      end
`endif
      if (evset) m_event = 1;
      else if (we_i && sl == 8'h05 && data_i[1]) m_event = 0;
      if (we_i) begin
        th = data_i[17:0];
        case (sl)
          8'h01: m_ctrl = data_i[1:0];
          8'h02: m_thhi = th;
          8'h03: m_thlo = th;
          default: ;
        endcase
      end
    end
  end

  function automatic logic [31:0] exp_read();
    logic [31:0] r;
    r = '0;
    if (!rst) begin
      case (addr_i[23:16])
        8'h01: r = {30'b0, m_ctrl};
        8'h02: r = {14'b0, m_thhi[17:0]};
        8'h03: r = {14'b0, m_thlo[17:0]};
        8'h04: r = m_avg;
        8'h05: r = {29'b0, m_avgv, m_event, m_alarm};
`ifdef TEMP_MINMAX_EN
        8'h06: r = m_min;
        8'h07: r = m_max;
`endif
        default: r = '0;
      endcase
    end
    return r;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("model alarm_o", {31'b0, alarm_o}, {31'b0, m_alarm});
    chk("model irq_o", {31'b0, irq_o}, {31'b0, m_event & m_ctrl[1]});
    chk("model data_o", data_o, exp_read());
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wr(logic [7:0] sl, logic [31:0] d);
    addr_i = {8'h00, sl, 16'h0000};
    data_i = d;
    we_i = 1'b1;
    cyc(1);
    we_i = 1'b0;
  endtask

  task automatic rd(string nm, logic [7:0] sl, logic [31:0] exp);
    addr_i = {8'h00, sl, 16'h0000};
    #1;
    chk(nm, data_o, exp);
  endtask

  task automatic run_window(logic [16:0] t);
    int c0, k;
    c0 = m_avg_cnt;
    k = 0;
    temp_i = t;
    while (m_avg_cnt == c0 && k < 64) begin
      cyc(1);
      k++;
    end
    if (m_avg_cnt == c0) begin
      total++; bad++;
      $display("FAIL window timeout: got no average expected one within 64 cycles");
    end
  endtask

  initial begin
    rst = 1'b1;
    cyc(3);
    rd("reset data_o", 8'h01, 32'h0);
    chk("reset alarm_o", {31'b0, alarm_o}, 32'h0);
    chk("reset irq_o", {31'b0, irq_o}, 32'h0);
    rst = 1'b0;
    rd("reset TH_HI", 8'h02, 32'h0001FFFF);
    rd("reset TH_LO", 8'h03, 32'h00020000);
    rd("reset STATUS", 8'h05, 32'h0);
    rd("reset AVG", 8'h04, 32'h0);

    // Constant +100 at full rate; average appears 16 cycles after enable.
    temp_i = 17'h00064;
    wr(8'h01, 32'h1);
    cyc(15);
    rd("avg before window", 8'h04, 32'h0);
    rd("status before window", 8'h05, 32'h0);
    cyc(1);
    rd("avg 100", 8'h04, 32'd100);
    rd("status avg_valid", 8'h05, 32'h4);

    // +3,+3,-4,-4 -> floor(-2/4) = -1; then negative zero -> 0.
    temp_i = 17'h00003; cyc(4);
    temp_i = 17'h00003; cyc(4);
    temp_i = 17'h10004; cyc(4);
    temp_i = 17'h10004; cyc(4);
    rd("avg -1", 8'h04, 32'hFFFFFFFF);
    temp_i = 17'h10000; cyc(16);
    rd("avg neg zero", 8'h04, 32'h0);

    // Hysteresis 50/40 with irq enabled.
    temp_i = 17'd45;
    wr(8'h02, 32'd50);
    wr(8'h03, 32'd40);
    wr(8'h01, 32'h3);
    run_window(17'd45); cyc(1);
    chk("alarm at 45", {31'b0, alarm_o}, 32'h0);
    run_window(17'd51); cyc(1);
    chk("alarm at 51", {31'b0, alarm_o}, 32'h1);
    chk("irq at 51", {31'b0, irq_o}, 32'h1);
    rd("status at 51", 8'h05, 32'h7);
    wr(8'h05, 32'h2);
    chk("irq after w1c", {31'b0, irq_o}, 32'h0);
    rd("status after w1c", 8'h05, 32'h5);
    run_window(17'd45); cyc(1);
    chk("alarm held at 45", {31'b0, alarm_o}, 32'h1);
    run_window(17'd39);
    wr(8'h05, 32'h2);
    chk("alarm at 39", {31'b0, alarm_o}, 32'h0);
    rd("set beats w1c", 8'h05, 32'h6);
    wr(8'h01, 32'h1);
    chk("irq masked", {31'b0, irq_o}, 32'h0);
    wr(8'h01, 32'h3);
    chk("irq unmasked", {31'b0, irq_o}, 32'h1);
    wr(8'h05, 32'h2);
    rd("later w1c", 8'h05, 32'h4);

    // Overlapping thresholds: LO=60 above HI=50.
    temp_i = 17'd55;
    wr(8'h03, 32'd60);
    run_window(17'd55); cyc(1);
    chk("overlap enter", {31'b0, alarm_o}, 32'h1);
    run_window(17'd55); cyc(1);
    chk("overlap exit", {31'b0, alarm_o}, 32'h0);

    // MIN/MAX tracking and re-arm.
    temp_i = 17'd10;
    wr(8'h06, 32'h0);
    run_window(17'd10);
    run_window(17'h10014);
    run_window(17'h0001E);
`ifdef TEMP_MINMAX_EN
    rd("min -20", 8'h06, 32'hFFFFFFEC);
    rd("max 30", 8'h07, 32'd30);
`else
    rd("min absent", 8'h06, 32'h0);
    rd("max absent", 8'h07, 32'h0);
`endif
    temp_i = 17'd5;
    wr(8'h06, 32'h0);
    run_window(17'd5);
`ifdef TEMP_MINMAX_EN
    rd("min rearm", 8'h06, 32'd5);
    rd("max rearm", 8'h07, 32'd5);
`else
    rd("min absent 2", 8'h06, 32'h0);
`endif

    // Reset mid-window with alarm active.
    temp_i = 17'd51;
    wr(8'h03, 32'd40);
    run_window(17'd51);
    cyc(2);
    chk("alarm before reset", {31'b0, alarm_o}, 32'h1);
    rst = 1'b1;
    cyc(1);
    chk("alarm after reset", {31'b0, alarm_o}, 32'h0);
    rst = 1'b0;
    rd("ctrl after reset", 8'h01, 32'h0);
    rd("avg after reset", 8'h04, 32'h0);
    rd("status after reset", 8'h05, 32'h0);
    rd("th_hi after reset", 8'h02, 32'h0001FFFF);
    cyc(8);
    rd("avg idle", 8'h04, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
